// File: rtl/bmem_arb_pkg.sv
// rtl/bmem_arb_pkg.sv - shared types for the bmem arbiter (optional perf counters: BMEM_ARB_PERF_EN)
package bmem_arb_pkg;
  localparam int BURST_LEN_DEF = 4;
  localparam int FIELD_W       = 8;

  typedef enum logic {IDLE, WBURST} arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [31:0]        addr;
    logic [FIELD_W-1:0] port;
    logic [FIELD_W-1:0] beat;
  } rd_entry_t;
endpackage

// File: rtl/bmem_arb_rr_picker.sv
// rtl/bmem_arb_rr_picker.sv - round-robin pick of one requester starting at ptr
module bmem_arb_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  int p;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int i = 0; i < N; i++) begin
      p = (int'(ptr) + i) % N;
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = PW'(p);
      end
    end
  end
endmodule

// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - N-port round-robin arbiter onto the burst-memory port
// Optional perf counters are built when BMEM_ARB_PERF_EN is defined.
module bmem_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int BURST_LEN       = BURST_LEN_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0][31:0] req_addr,
  input  logic [NUM_PORTS-1:0]       req_read,
  input  logic [NUM_PORTS-1:0]       req_write,
  input  logic [NUM_PORTS-1:0][63:0] req_wdata,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic [NUM_PORTS-1:0]       resp_rvalid,
  output logic [31:0]                resp_raddr,
  output logic [63:0]                resp_rdata,
  output logic                       err_unmatched,
  output logic [31:0]                bmem_addr,
  output logic                       bmem_read,
  output logic                       bmem_write,
  output logic [63:0]                bmem_wdata,
  input  logic                       bmem_ready,
  input  logic [31:0]                bmem_raddr,
  input  logic [63:0]                bmem_rdata,
  input  logic                       bmem_rvalid
`ifdef BMEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS-1:0][31:0] perf_grants,
  output logic [31:0]                perf_full_stalls
`endif
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int TIDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  arb_state_t           state, state_nxt;
  logic [PORT_W-1:0]    rr_ptr, lock_port, win_idx;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [31:0]          burst_addr;
  rd_entry_t            tbl [MAX_OUTSTANDING];
  logic                 full, free_found, hit, win_any;
  logic [TIDX_W-1:0]    free_idx, hit_idx;
  logic [NUM_PORTS-1:0] dup, elig, win_grant;
  logic                 rd_accept, wr_start, wr_beat;

  // Table lookups use registered state only, so a freed entry is reusable next cycle.
  always_comb begin
    full       = 1'b1;
    free_found = 1'b0;
    free_idx   = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    dup        = '0;
    for (int t = 0; t < MAX_OUTSTANDING; t++) begin
      if (!tbl[t].valid) begin
        full = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = TIDX_W'(t);
        end
      end else begin
        if (bmem_rvalid && !hit && tbl[t].addr == bmem_raddr) begin
          hit     = 1'b1;
          hit_idx = TIDX_W'(t);
        end
        for (int q = 0; q < NUM_PORTS; q++)
          if (tbl[t].addr == req_addr[q]) dup[q] = 1'b1;
      end
    end
  end

  assign elig = (req_read & ~dup & {NUM_PORTS{~full}}) | req_write;

  bmem_arb_rr_picker #(.N(NUM_PORTS), .PW(PORT_W)) u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_nxt  = state;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    req_ready  = '0;
    rd_accept  = 1'b0;
    wr_start   = 1'b0;
    wr_beat    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (win_any) begin
          bmem_addr = req_addr[win_idx];
          req_ready = win_grant & {NUM_PORTS{bmem_ready}};
          if (req_write[win_idx]) begin
            bmem_write = 1'b1;
            bmem_wdata = req_wdata[win_idx];
            wr_start   = bmem_ready;
            if (bmem_ready && BURST_LEN > 1) state_nxt = WBURST;
          end else begin
            bmem_read = 1'b1;
            rd_accept = bmem_ready;
          end
        end
        WBURST: begin
          // A dropped req_write simply pauses the burst until the owner returns.
          bmem_addr          = burst_addr;
          bmem_write         = req_write[lock_port];
          bmem_wdata         = req_write[lock_port] ? req_wdata[lock_port] : '0;
          wr_beat            = req_write[lock_port] & bmem_ready;
          req_ready[lock_port] = wr_beat;
          if (wr_beat && beat_cnt == BEAT_W'(BURST_LEN - 1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      lock_port     <= '0;
      beat_cnt      <= '0;
      burst_addr    <= '0;
      err_unmatched <= 1'b0;
      resp_rvalid   <= '0;
      resp_raddr    <= '0;
      resp_rdata    <= '0;
      for (int t = 0; t < MAX_OUTSTANDING; t++) tbl[t] <= '0;
    end else begin
      state <= state_nxt;
      if (rd_accept || wr_start)
        rr_ptr <= (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + PORT_W'(1);
      if (wr_start) begin
        lock_port  <= win_idx;
        burst_addr <= req_addr[win_idx];
        beat_cnt   <= BEAT_W'(1);
      end else if (wr_beat) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      if (rd_accept)
        tbl[free_idx] <= '{valid: 1'b1, addr: req_addr[win_idx],
                           port: FIELD_W'(win_idx), beat: '0};
      resp_rvalid <= '0;
      if (bmem_rvalid) begin
        if (hit) begin
          resp_rvalid <= NUM_PORTS'(1) << tbl[hit_idx].port;
          resp_raddr  <= bmem_raddr;
          resp_rdata  <= bmem_rdata;
          if (tbl[hit_idx].beat == FIELD_W'(BURST_LEN - 1))
            tbl[hit_idx].valid <= 1'b0;
          else
            tbl[hit_idx].beat <= tbl[hit_idx].beat + FIELD_W'(1);
        end else begin
          err_unmatched <= 1'b1;
        end
      end
    end
  end

`ifdef BMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants      <= '0;
      perf_full_stalls <= '0;
    end else begin
      for (int q = 0; q < NUM_PORTS; q++)
        if ((rd_accept || wr_start) && win_idx == PORT_W'(q) && perf_grants[q] != '1)
          perf_grants[q] <= perf_grants[q] + 32'd1;
      if (|req_read && full && perf_full_stalls != '1)
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif
endmodule
